// File: rtl/ttl_decoder_rr_arbiter.sv
// Round-robin arbiter presenting the winner as a binary select (A) and a one-hot grant (Y),
// with a bounded hold time and a forced idle cycle between consecutive grants.
module ttl_decoder_rr_arbiter #(
   parameter int WIDTH_OUT  = 8,
   parameter int WIDTH_IN   = $clog2(WIDTH_OUT),
   parameter int HOLD_MAX   = 4,
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input  logic                 Clk,
   input  logic                 Clear_bar,
   input  logic                 Enable,
   input  logic [WIDTH_OUT-1:0] Request,
   input  logic                 Done,
   output logic [WIDTH_IN-1:0]  A,
   output logic [WIDTH_OUT-1:0] Y,
   output logic                 Valid
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
   localparam bit PARAMS_OK = (HOLD_MAX >= 1) && (HOLD_MAX <= 255) &&
                              (DELAY_RISE >= 0) && (DELAY_FALL >= 0);

   state_t               state;
   logic [WIDTH_IN-1:0]  ptr;
   logic [7:0]           hold;
   logic [WIDTH_IN-1:0]  a_p0;
   logic [WIDTH_OUT-1:0] y_p0;
   logic                 vld_p0;

   logic                 win_found;
   logic [WIDTH_IN-1:0]  win_idx;
   logic                 release_now;
   logic [WIDTH_IN-1:0]  ptr_next;

   // First requester at or after ptr, wrapping; the releasing grantee sits last in line.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < WIDTH_OUT; k++) begin
         if (!win_found && Request[WIDTH_IN'((int'(ptr) + k) % WIDTH_OUT)]) begin
            win_found = 1'b1;
            win_idx   = WIDTH_IN'((int'(ptr) + k) % WIDTH_OUT);
         end
      end
   end

   always_comb begin
      release_now = Done || !Request[a_p0] || !Enable || (hold == HOLD_LIM);
      if (int'(a_p0) == WIDTH_OUT - 1)
         ptr_next = '0;
      else
         ptr_next = a_p0 + WIDTH_IN'(1);
   end

   always_ff @(posedge Clk) begin
      if (!Clear_bar) begin
         state  <= IDLE;
         ptr    <= '0;
         hold   <= '0;
         a_p0   <= '0;
         y_p0   <= '0;
         vld_p0 <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Enable && win_found) begin
                  a_p0   <= win_idx;
                  y_p0   <= WIDTH_OUT'(1) << win_idx;
                  vld_p0 <= 1'b1;
                  hold   <= 8'd1;
                  state  <= GRANT;
               end
            end
            GRANT: begin
               if (release_now) begin
                  y_p0   <= '0;
                  vld_p0 <= 1'b0;
                  ptr    <= ptr_next;
                  hold   <= '0;
                  state  <= IDLE;
               end else begin
                  hold   <= hold + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Propagation delays belong to the downstream discrete parts; the registered outputs carry
   // none here, so an illegal parameter set simply keeps every grant off.
   if (PARAMS_OK) begin : g_out
      assign A     = a_p0;
      assign Y     = y_p0;
      assign Valid = vld_p0;
   end else begin : g_out_off
      assign A     = '0;
      assign Y     = '0;
      assign Valid = 1'b0;
   end

endmodule

// File: tb/tb_ttl_decoder_rr_arbiter.sv
// Directed bench for ttl_decoder_rr_arbiter: reset, single grant, wrap, hold limit,
// withdrawal, enable drop, reset mid-grant and a coincident Done/hold-limit release.
module tb_ttl_decoder_rr_arbiter;

   logic       Clk = 1'b0;
   logic       Clear_bar;
   logic       Enable;
   logic [7:0] Request;
   logic       Done;
   logic [2:0] A;
   logic [7:0] Y;
   logic       Valid;

   int checks = 0;
   int errors = 0;

   ttl_decoder_rr_arbiter #(
      .WIDTH_OUT(8), .WIDTH_IN(3), .HOLD_MAX(4), .DELAY_RISE(0), .DELAY_FALL(0)
   ) dut (
      .Clk(Clk), .Clear_bar(Clear_bar), .Enable(Enable), .Request(Request),
      .Done(Done), .A(A), .Y(Y), .Valid(Valid)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_y(input string tag, input logic [7:0] exp_y);
      check({tag, ".Y"}, 32'(Y), 32'(exp_y));
      check({tag, ".Valid"}, 32'(Valid), 32'(exp_y != 8'h00));
   endtask

   logic [7:0] wrap_seq [7] = '{8'h01, 8'h00, 8'h80, 8'h00, 8'h01, 8'h00, 8'h80};
   logic [7:0] hold_seq [11] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h00,
                                 8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h02};

   initial begin
      Clear_bar = 1'b0; Enable = 1'b1; Request = 8'hFF; Done = 1'b0;

      // Reset held for two edges against full requests.
      tick(); tick();
      check_y("reset", 8'h00);
      check("reset.A", 32'(A), 32'd0);
      Clear_bar = 1'b1;
      tick();
      check_y("first_grant", 8'h01);
      check("first_grant.A", 32'(A), 32'd0);
      Done = 1'b1;
      tick();
      check_y("first_release", 8'h00);
      Done = 1'b0; Request = 8'h00;
      tick();
      check_y("idle_no_req", 8'h00);

      // Single requester 4, released by Done on the third edge.
      Request = 8'h10;
      tick();
      check_y("single.e1", 8'h10);
      check("single.A", 32'(A), 32'd4);
      tick();
      check_y("single.e2", 8'h10);
      Done = 1'b1;
      tick();
      check_y("single.e3", 8'h00);
      check("single.A_held", 32'(A), 32'd4);
      Done = 1'b0; Request = 8'h31;
      tick();
      check_y("ptr_after_4", 8'h20);
      check("ptr_after_4.A", 32'(A), 32'd5);
      Request = 8'h00;
      tick();
      check_y("withdraw_5", 8'h00);

      // Wrap between requesters 0 and 7 from Ptr=0.
      Clear_bar = 1'b0;
      tick();
      Clear_bar = 1'b1; Request = 8'h81; Done = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         check_y($sformatf("wrap[%0d]", i), wrap_seq[i]);
      end
      Done = 1'b0; Request = 8'h00;
      tick();
      check_y("wrap_end", 8'h00);

      // Hold limit of 4 alternating between requesters 1 and 2.
      Request = 8'h06;
      for (int i = 0; i < 11; i++) begin
         tick();
         check_y($sformatf("hold[%0d]", i), hold_seq[i]);
      end

      // Withdrawal of requester 3 leaves Ptr at 4.
      Request = 8'h00;
      tick();
      check_y("hold_exit", 8'h00);
      Request = 8'h08;
      tick();
      check_y("grant3", 8'h08);
      check("grant3.A", 32'(A), 32'd3);
      Request = 8'h00;
      tick();
      check_y("withdraw3", 8'h00);
      Request = 8'h18;
      tick();
      check_y("ptr_after_3", 8'h10);
      check("ptr_after_3.A", 32'(A), 32'd4);

      // Enable drop releases and blocks new grants.
      Enable = 1'b0;
      tick();
      check_y("enable_drop", 8'h00);
      tick();
      check_y("enable_low1", 8'h00);
      tick();
      check_y("enable_low2", 8'h00);
      Enable = 1'b1;
      tick();
      check_y("enable_back", 8'h08);
      check("enable_back.A", 32'(A), 32'd3);

      // Reset in the middle of a grant to requester 5.
      Request = 8'h00;
      tick();
      Request = 8'h20;
      tick();
      tick();
      check_y("grant5.hold2", 8'h20);
      Clear_bar = 1'b0; Request = 8'h21;
      tick();
      check_y("reset_mid", 8'h00);
      check("reset_mid.A", 32'(A), 32'd0);
      Clear_bar = 1'b1;
      tick();
      check_y("after_reset", 8'h01);
      check("after_reset.A", 32'(A), 32'd0);

      // Done coinciding with the hold limit advances Ptr only once.
      Request = 8'h03;
      tick(); tick(); tick();
      check_y("hold4", 8'h01);
      Done = 1'b1;
      tick();
      check_y("done_at_limit", 8'h00);
      Done = 1'b0;
      tick();
      check_y("single_advance", 8'h02);
      check("single_advance.A", 32'(A), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
